// File: rtl/forwarding_hazard_unit_if.sv
// Bundle of operand, pipeline-stage and stall signals for forwarding_hazard_unit.
//   master: pipeline side; drives operands and stage info, receives forwarded data and stall.
//   slave : the forwarding/hazard unit itself.
// Signals:
//   flush                   sync clear of retired-write history and stall FSM
//   src_valid/index/data    per-operand use flag, register index and regfile read data
//   EX/MEM/WB_opcode/index  per-stage opcode and destination register
//   MEM_data/WB_data        results available for forwarding
//   data_forwarded/fwd_sel  selected operand data and its source (0 rf, 1 MEM, 2 WB, 3 HIST)
//   stall/stall_cycles      load-use stall request and saturating stalled-cycle count
interface forwarding_hazard_unit_if #(
  parameter int unsigned REG_INDEX_BIT_WIDTH = 4,
  parameter int unsigned bitwidth            = 32,
  parameter int unsigned NUM_SRC             = 2
);
  logic                                   flush;
  logic [NUM_SRC-1:0]                     src_valid;
  logic [NUM_SRC*REG_INDEX_BIT_WIDTH-1:0] src_index;
  logic [NUM_SRC*bitwidth-1:0]            src_data;
  logic [3:0]                             EX_opcode;
  logic [REG_INDEX_BIT_WIDTH-1:0]         EX_index;
  logic [3:0]                             MEM_opcode;
  logic [REG_INDEX_BIT_WIDTH-1:0]         MEM_index;
  logic [bitwidth-1:0]                    MEM_data;
  logic [3:0]                             WB_opcode;
  logic [REG_INDEX_BIT_WIDTH-1:0]         WB_index;
  logic [bitwidth-1:0]                    WB_data;
  logic [NUM_SRC*bitwidth-1:0]            data_forwarded;
  logic [NUM_SRC*2-1:0]                   fwd_sel;
  logic                                   stall;
  logic [15:0]                            stall_cycles;

  modport master (
    output flush, src_valid, src_index, src_data,
    output EX_opcode, EX_index, MEM_opcode, MEM_index, MEM_data,
    output WB_opcode, WB_index, WB_data,
    input  data_forwarded, fwd_sel, stall, stall_cycles
  );

  modport slave (
    input  flush, src_valid, src_index, src_data,
    input  EX_opcode, EX_index, MEM_opcode, MEM_index, MEM_data,
    input  WB_opcode, WB_index, WB_data,
    output data_forwarded, fwd_sel, stall, stall_cycles
  );
endinterface

// File: rtl/forwarding_hazard_unit.sv
// Operand forwarding and load-use hazard unit for the 5-stage pipeline.
// Forwards each source operand from MEM, WB or a retired-write history (newest first),
// falling back to register-file data, and stalls on load-use hazards for LOAD_LATENCY cycles.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    forwarding_hazard_unit_if slave modport (operands, stage info, outputs)
module forwarding_hazard_unit #(
  parameter int unsigned REG_INDEX_BIT_WIDTH = 4,
  parameter int unsigned bitwidth            = 32,
  parameter int unsigned NUM_SRC             = 2,
  parameter int unsigned HIST_DEPTH          = 2,
  parameter int unsigned LOAD_LATENCY        = 1,
  parameter logic [3:0]  BRANCH_OP           = 4'b0010,
  parameter logic [3:0]  SW_OP               = 4'b0011,
  parameter logic [3:0]  LW_OP               = 4'b1000
) (
  input logic                    clk,
  input logic                    rst_n,
  forwarding_hazard_unit_if.slave bus
);
  localparam int unsigned RW = REG_INDEX_BIT_WIDTH;
  localparam int unsigned DW = bitwidth;

  typedef enum logic [0:0] {StIdle, StStall} state_e;

  function automatic logic writes(input logic [3:0] op);
    return (op != BRANCH_OP) && (op != SW_OP);
  endfunction

  state_e                        state_q, state_d;
  logic [2:0]                    cnt_q, cnt_d;
  logic [15:0]                   stall_cycles_q, stall_cycles_d;
  logic [HIST_DEPTH-1:0]         hist_vld_q, hist_vld_d;
  logic [HIST_DEPTH-1:0][RW-1:0] hist_idx_q, hist_idx_d;
  logic [HIST_DEPTH-1:0][DW-1:0] hist_dat_q, hist_dat_d;

  logic mem_fwd_ok, wb_wr, hazard, stall;
  logic [NUM_SRC*DW-1:0] fwd_data;
  logic [NUM_SRC*2-1:0]  fwd_sel;

  // A load in MEM has no data yet, so it never forwards.
  assign mem_fwd_ok = writes(bus.MEM_opcode) && (bus.MEM_opcode != LW_OP);
  assign wb_wr      = writes(bus.WB_opcode);

  // Per-operand mux: apply sources lowest priority first so later hits override.
  always_comb begin
    fwd_data = '0;
    fwd_sel  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      logic [RW-1:0] idx;
      logic [DW-1:0] dat;
      logic [1:0]    sel;
      idx = bus.src_index[i*RW +: RW];
      dat = bus.src_data[i*DW +: DW];
      sel = 2'd0;
      if (bus.src_valid[i]) begin
        for (int h = HIST_DEPTH - 1; h >= 0; h--) begin
          if (hist_vld_q[h] && (hist_idx_q[h] == idx)) begin
            dat = hist_dat_q[h];
            sel = 2'd3;
          end
        end
        if (wb_wr && (bus.WB_index == idx)) begin
          dat = bus.WB_data;
          sel = 2'd2;
        end
        if (mem_fwd_ok && (bus.MEM_index == idx)) begin
          dat = bus.MEM_data;
          sel = 2'd1;
        end
      end
      fwd_data[i*DW +: DW] = dat;
      fwd_sel[i*2 +: 2]    = sel;
    end
  end

  always_comb begin
    hazard = 1'b0;
    if (bus.EX_opcode == LW_OP) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (bus.src_valid[i] && (bus.src_index[i*RW +: RW] == bus.EX_index)) hazard = 1'b1;
      end
    end
  end

  // IDLE raises stall in the hazard cycle itself; STALL holds it regardless of inputs.
  assign stall = (state_q == StStall) || (hazard && !bus.flush);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    stall_cycles_d = stall_cycles_q;
    hist_vld_d     = hist_vld_q;
    hist_idx_d     = hist_idx_q;
    hist_dat_d     = hist_dat_q;

    if (stall && (stall_cycles_q != 16'hFFFF)) stall_cycles_d = stall_cycles_q + 16'd1;

    if (bus.flush) begin
      state_d = StIdle;
      cnt_d   = 3'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (hazard && (LOAD_LATENCY > 1)) begin
            state_d = StStall;
            cnt_d   = 3'(LOAD_LATENCY - 1);
          end
        end
        StStall: begin
          if (cnt_q <= 3'd1) begin
            state_d = StIdle;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = 3'd0;
        end
      endcase
    end

    // Flush wins over a same-cycle WB push.
    if (bus.flush) begin
      hist_vld_d = '0;
    end else begin
      for (int h = HIST_DEPTH - 1; h >= 1; h--) begin
        hist_vld_d[h] = hist_vld_q[h-1];
        hist_idx_d[h] = hist_idx_q[h-1];
        hist_dat_d[h] = hist_dat_q[h-1];
      end
      hist_vld_d[0] = wb_wr;
      hist_idx_d[0] = bus.WB_index;
      hist_dat_d[0] = bus.WB_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= 3'd0;
      stall_cycles_q <= 16'd0;
      hist_vld_q     <= '0;
      hist_idx_q     <= '0;
      hist_dat_q     <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
      hist_vld_q     <= hist_vld_d;
      hist_idx_q     <= hist_idx_d;
      hist_dat_q     <= hist_dat_d;
    end
  end

  assign bus.data_forwarded = fwd_data;
  assign bus.fwd_sel        = fwd_sel;
  assign bus.stall          = stall;
  assign bus.stall_cycles   = stall_cycles_q;
endmodule

// File: tb/tb_forwarding_hazard_unit.sv
module tb_forwarding_hazard_unit;
  localparam int unsigned RW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned NS = 2;
  localparam int unsigned HD = 2;
  localparam int unsigned LL = 2;
  localparam logic [3:0] ADD = 4'b1100;
  localparam logic [3:0] BR  = 4'b0010;
  localparam logic [3:0] SW  = 4'b0011;
  localparam logic [3:0] LW  = 4'b1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  forwarding_hazard_unit_if #(.REG_INDEX_BIT_WIDTH(RW), .bitwidth(DW), .NUM_SRC(NS)) bus ();

  forwarding_hazard_unit #(
    .REG_INDEX_BIT_WIDTH(RW), .bitwidth(DW), .NUM_SRC(NS),
    .HIST_DEPTH(HD), .LOAD_LATENCY(LL),
    .BRANCH_OP(BR), .SW_OP(SW), .LW_OP(LW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: history as a newest-first list, stall as "extra cycles still owed".
  typedef struct {
    bit            v;
    logic [RW-1:0] idx;
    logic [DW-1:0] data;
  } hent_t;
  hent_t       hist[$];
  int          owed;
  int unsigned scount;

  function automatic bit wr(input logic [3:0] op);
    return (op != BR) && (op != SW);
  endfunction

  function automatic void model_reset();
    hent_t e;
    e.v = 0; e.idx = '0; e.data = '0;
    hist.delete();
    for (int k = 0; k < HD; k++) hist.push_back(e);
    owed = 0;
    scount = 0;
  endfunction

  function automatic void exp_fwd(input int i, output logic [DW-1:0] d, output logic [1:0] s);
    logic [RW-1:0] idx;
    idx = bus.src_index[i*RW +: RW];
    d = bus.src_data[i*DW +: DW];
    s = 2'd0;
    if (!bus.src_valid[i]) return;
    if (wr(bus.MEM_opcode) && bus.MEM_opcode != LW && bus.MEM_index == idx) begin
      d = bus.MEM_data; s = 2'd1; return;
    end
    if (wr(bus.WB_opcode) && bus.WB_index == idx) begin
      d = bus.WB_data; s = 2'd2; return;
    end
    foreach (hist[k]) begin
      if (hist[k].v && hist[k].idx == idx) begin
        d = hist[k].data; s = 2'd3; return;
      end
    end
  endfunction

  function automatic bit exp_hazard();
    bit hz = 0;
    if (bus.EX_opcode == LW)
      for (int i = 0; i < NS; i++)
        if (bus.src_valid[i] && bus.src_index[i*RW +: RW] == bus.EX_index) hz = 1;
    return hz;
  endfunction

  function automatic bit exp_stall();
    return (owed > 0) || (exp_hazard() && !bus.flush);
  endfunction

  function automatic void model_edge();
    hent_t e;
    bit st, hz;
    st = exp_stall();
    hz = exp_hazard();
    if (st && scount < 65535) scount++;
    if (bus.flush) owed = 0;
    else if (owed > 0) owed--;
    else if (hz) owed = LL - 1;
    if (bus.flush) begin
      foreach (hist[k]) hist[k].v = 0;
    end else begin
      e.v = wr(bus.WB_opcode); e.idx = bus.WB_index; e.data = bus.WB_data;
      hist.push_front(e);
      void'(hist.pop_back());
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive_idle();
    bus.flush = 0; bus.src_valid = '0; bus.src_index = '0; bus.src_data = '0;
    bus.EX_opcode = ADD; bus.EX_index = '0;
    bus.MEM_opcode = BR; bus.MEM_index = '0; bus.MEM_data = '0;
    bus.WB_opcode = BR; bus.WB_index = '0; bus.WB_data = '0;
  endtask

  task automatic set_src(input int i, input bit v, input logic [RW-1:0] idx,
                         input logic [DW-1:0] d);
    bus.src_valid[i] = v;
    bus.src_index[i*RW +: RW] = idx;
    bus.src_data[i*DW +: DW] = d;
  endtask

  function automatic logic [3:0] rand_op();
    case ($urandom_range(4))
      0: return ADD;
      1: return BR;
      2: return SW;
      3: return LW;
      default: return 4'($urandom);
    endcase
  endfunction

  task automatic test_reset();
    drive_idle();
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      failures++; $display("FAIL reset_stall got=%b exp=0", bus.stall);
    end
    checks++;
    if (bus.stall_cycles !== 16'd0) begin
      failures++; $display("FAIL reset_stall_cycles got=%0d exp=0", bus.stall_cycles);
    end
    checks++;
    if (bus.fwd_sel !== 4'd0) begin
      failures++; $display("FAIL reset_fwd_sel got=%h exp=0", bus.fwd_sel);
    end
  endtask

  task automatic test_priority();
    drive_idle();
    set_src(0, 1, 4'd0, 32'h1111); set_src(1, 0, 4'd7, 32'h2222);
    bus.MEM_opcode = ADD; bus.MEM_index = 4'd1; bus.MEM_data = 32'd1;
    bus.WB_opcode = ADD; bus.WB_index = 4'd2; bus.WB_data = 32'd2;
    #1;
    checks++;
    if (bus.data_forwarded[31:0] !== 32'h1111 || bus.fwd_sel[1:0] !== 2'd0) begin
      failures++; $display("FAIL prio_distinct got=%h/%0d exp=1111/0",
                           bus.data_forwarded[31:0], bus.fwd_sel[1:0]);
    end
    bus.MEM_index = 4'd0; bus.WB_index = 4'd0;
    #1;
    checks++;
    if (bus.data_forwarded[31:0] !== 32'd1 || bus.fwd_sel[1:0] !== 2'd1) begin
      failures++; $display("FAIL prio_mem got=%h/%0d exp=1/1",
                           bus.data_forwarded[31:0], bus.fwd_sel[1:0]);
    end
    bus.MEM_opcode = BR;
    #1;
    checks++;
    if (bus.data_forwarded[31:0] !== 32'd2 || bus.fwd_sel[1:0] !== 2'd2) begin
      failures++; $display("FAIL prio_wb got=%h/%0d exp=2/2",
                           bus.data_forwarded[31:0], bus.fwd_sel[1:0]);
    end
    bus.MEM_opcode = SW; bus.WB_opcode = SW;
    #1;
    checks++;
    if (bus.data_forwarded[31:0] !== 32'h1111 || bus.fwd_sel[1:0] !== 2'd0) begin
      failures++; $display("FAIL prio_sw got=%h/%0d exp=1111/0",
                           bus.data_forwarded[31:0], bus.fwd_sel[1:0]);
    end
  endtask

  task automatic test_history();
    logic [DW-1:0] exp_d[3] = '{32'hAA, 32'hAA, 32'h5555};
    logic [1:0]    exp_s[3] = '{2'd3, 2'd3, 2'd0};
    drive_idle();
    set_src(1, 1, 4'd5, 32'h5555);
    bus.WB_opcode = ADD; bus.WB_index = 4'd5; bus.WB_data = 32'hAA;
    #1;
    checks++;
    if (bus.data_forwarded[63:32] !== 32'hAA || bus.fwd_sel[3:2] !== 2'd2) begin
      failures++; $display("FAIL hist_wb got=%h/%0d exp=aa/2",
                           bus.data_forwarded[63:32], bus.fwd_sel[3:2]);
    end
    step();
    bus.WB_opcode = BR;
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++;
      if (bus.data_forwarded[63:32] !== exp_d[n] || bus.fwd_sel[3:2] !== exp_s[n]) begin
        failures++; $display("FAIL hist_age%0d got=%h/%0d exp=%h/%0d", n,
                             bus.data_forwarded[63:32], bus.fwd_sel[3:2], exp_d[n], exp_s[n]);
      end
      step();
    end
  endtask

  task automatic test_load_use();
    drive_idle();
    bus.EX_opcode = LW; bus.EX_index = 4'd3;
    set_src(0, 1, 4'd3, 32'h3);
    for (int n = 0; n < 2; n++) begin
      #1;
      checks++;
      if (bus.stall !== 1'b1) begin
        failures++; $display("FAIL lu_stall%0d got=%b exp=1", n, bus.stall);
      end
      step();
    end
    bus.EX_opcode = ADD;
    #1;
    checks++;
    if (bus.stall !== 1'b0 || bus.stall_cycles !== 16'd2) begin
      failures++; $display("FAIL lu_end got=%b/%0d exp=0/2", bus.stall, bus.stall_cycles);
    end
    bus.EX_opcode = LW; bus.src_valid = '0;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      failures++; $display("FAIL lu_invalid got=%b exp=0", bus.stall);
    end
    step();
    checks++;
    if (bus.stall_cycles !== 16'd2) begin
      failures++; $display("FAIL lu_count got=%0d exp=2", bus.stall_cycles);
    end
  endtask

  task automatic test_mem_load();
    drive_idle();
    set_src(0, 1, 4'd4, 32'h4444);
    bus.MEM_opcode = LW; bus.MEM_index = 4'd4; bus.MEM_data = 32'hDEAD;
    bus.WB_opcode = ADD; bus.WB_index = 4'd4; bus.WB_data = 32'h55;
    #1;
    checks++;
    if (bus.data_forwarded[31:0] !== 32'h55 || bus.fwd_sel[1:0] !== 2'd2) begin
      failures++; $display("FAIL mlw_wb got=%h/%0d exp=55/2",
                           bus.data_forwarded[31:0], bus.fwd_sel[1:0]);
    end
    bus.WB_opcode = BR;
    #1;
    checks++;
    if (bus.data_forwarded[31:0] !== 32'h4444 || bus.fwd_sel[1:0] !== 2'd0) begin
      failures++; $display("FAIL mlw_rf got=%h/%0d exp=4444/0",
                           bus.data_forwarded[31:0], bus.fwd_sel[1:0]);
    end
    bus.WB_opcode = ADD; bus.WB_data = 32'h77; bus.MEM_opcode = BR;
    step();
    bus.WB_opcode = BR; bus.MEM_opcode = LW;
    #1;
    checks++;
    if (bus.data_forwarded[31:0] !== 32'h77 || bus.fwd_sel[1:0] !== 2'd3) begin
      failures++; $display("FAIL mlw_hist got=%h/%0d exp=77/3",
                           bus.data_forwarded[31:0], bus.fwd_sel[1:0]);
    end
  endtask

  task automatic test_flush();
    drive_idle();
    bus.WB_opcode = ADD; bus.WB_index = 4'd9; bus.WB_data = 32'h99;
    step();
    bus.WB_opcode = BR;
    set_src(0, 1, 4'd9, 32'h9090);
    #1;
    checks++;
    if (bus.data_forwarded[31:0] !== 32'h99 || bus.fwd_sel[1:0] !== 2'd3) begin
      failures++; $display("FAIL fl_pre got=%h/%0d exp=99/3",
                           bus.data_forwarded[31:0], bus.fwd_sel[1:0]);
    end
    bus.EX_opcode = LW; bus.EX_index = 4'd9;
    step();
    bus.flush = 1; bus.WB_opcode = ADD; bus.WB_data = 32'h123; bus.EX_opcode = ADD;
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin
      failures++; $display("FAIL fl_in_stall got=%b exp=1", bus.stall);
    end
    step();
    bus.flush = 0; bus.WB_opcode = BR;
    #1;
    checks++;
    if (bus.stall !== 1'b0 || bus.fwd_sel[1:0] !== 2'd0 ||
        bus.data_forwarded[31:0] !== 32'h9090) begin
      failures++; $display("FAIL fl_after got=%b/%0d/%h exp=0/0/9090", bus.stall,
                           bus.fwd_sel[1:0], bus.data_forwarded[31:0]);
    end
    bus.EX_opcode = LW; bus.flush = 1;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      failures++; $display("FAIL fl_suppress got=%b exp=0", bus.stall);
    end
    step();
    bus.flush = 0; bus.EX_opcode = ADD;
    #1;
    checks++;
    if (bus.stall !== 1'b0 || bus.stall_cycles !== 16'(scount)) begin
      failures++; $display("FAIL fl_idle got=%b/%0d exp=0/%0d", bus.stall,
                           bus.stall_cycles, scount);
    end
  endtask

  task automatic test_async_reset();
    drive_idle();
    bus.EX_opcode = LW; bus.EX_index = 4'd2;
    set_src(0, 1, 4'd2, 32'h2);
    step();
    bus.EX_opcode = ADD;
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin
      failures++; $display("FAIL ar_pre got=%b exp=1", bus.stall);
    end
    rst_n = 0;
    #1;
    checks++;
    if (bus.stall !== 1'b0 || bus.stall_cycles !== 16'd0) begin
      failures++; $display("FAIL ar_reset got=%b/%0d exp=0/0", bus.stall, bus.stall_cycles);
    end
    model_reset();
    rst_n = 1;
  endtask

  task automatic test_random();
    logic [DW-1:0] ed;
    logic [1:0]    es;
    for (int n = 0; n < 400; n++) begin
      bus.flush = ($urandom_range(15) == 0);
      for (int i = 0; i < NS; i++) set_src(i, 1'($urandom), 4'($urandom_range(3)), $urandom);
      bus.EX_opcode = rand_op(); bus.EX_index = 4'($urandom_range(3));
      bus.MEM_opcode = rand_op(); bus.MEM_index = 4'($urandom_range(3)); bus.MEM_data = $urandom;
      bus.WB_opcode = rand_op(); bus.WB_index = 4'($urandom_range(3)); bus.WB_data = $urandom;
      #1;
      for (int i = 0; i < NS; i++) begin
        exp_fwd(i, ed, es);
        checks++;
        if (bus.data_forwarded[i*DW +: DW] !== ed || bus.fwd_sel[i*2 +: 2] !== es) begin
          failures++; $display("FAIL rnd_fwd n=%0d op=%0d got=%h/%0d exp=%h/%0d", n, i,
                               bus.data_forwarded[i*DW +: DW], bus.fwd_sel[i*2 +: 2], ed, es);
        end
      end
      checks++;
      if (bus.stall !== exp_stall() || bus.stall_cycles !== 16'(scount)) begin
        failures++; $display("FAIL rnd_stall n=%0d got=%b/%0d exp=%b/%0d", n, bus.stall,
                             bus.stall_cycles, exp_stall(), scount);
      end
      step();
    end
  endtask

  task automatic test_saturation();
    drive_idle();
    bus.EX_opcode = LW; bus.EX_index = 4'd1;
    set_src(0, 1, 4'd1, 32'h1);
    repeat (65540) step();
    #1;
    checks++;
    if (bus.stall_cycles !== 16'hFFFF || bus.stall_cycles !== 16'(scount)) begin
      failures++; $display("FAIL sat got=%0d exp=65535 model=%0d", bus.stall_cycles, scount);
    end
  endtask

  initial begin
    model_reset();
    drive_idle();
    #2;
    test_reset();
    rst_n = 1;
    @(negedge clk);
    test_priority();
    test_history();
    test_load_use();
    test_mem_load();
    test_flush();
    test_async_reset();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
